// File: rtl/soc_bus_fabric_pkg.sv
// Shared types and defaults for the data-side bus fabric: FSM encoding,
// default region codes and default bus widths.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } bus_state_t;

  localparam logic [3:0] REG_RAM  = 4'h4;
  localparam logic [3:0] REG_ROM  = 4'h0;
  localparam logic [3:0] REG_UART = 4'he;
  localparam logic [3:0] REG_GPIO = 4'hd;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 32;

endpackage

// File: rtl/soc_bus_fabric_if.sv
// Core RAM-port side and slave-side signals of the bus fabric.
// The fabric uses the slave modport; the core/slave environment uses master.
interface soc_bus_fabric_if #(
  parameter int N_SLV = 4,
  parameter int DW    = 32,
  parameter int AW    = 32
);
  logic [AW-1:0]       m_addr;
  logic                m_cen;
  logic                m_wen;
  logic [DW/8-1:0]     m_flag;
  logic [DW-1:0]       m_wdata;
  logic [DW-1:0]       m_rdata;
  logic                m_wait;
  logic                m_abort;
  logic [N_SLV-1:0]    s_ce;
  logic [AW-1:0]       s_addr;
  logic                s_wen;
  logic [DW/8-1:0]     s_flag;
  logic [DW-1:0]       s_wdata;
  logic [N_SLV*DW-1:0] s_rdata;
  logic [N_SLV-1:0]    s_wait;

  modport master (
    output m_addr, m_cen, m_wen, m_flag, m_wdata, s_rdata, s_wait,
    input  m_rdata, m_wait, m_abort, s_ce, s_addr, s_wen, s_flag, s_wdata
  );

  modport slave (
    input  m_addr, m_cen, m_wen, m_flag, m_wdata, s_rdata, s_wait,
    output m_rdata, m_wait, m_abort, s_ce, s_addr, s_wen, s_flag, s_wdata
  );
endinterface

// File: rtl/soc_bus_fabric_wait_timer.sv
// Saturating wait-cycle counter: start loads 1 (first stalled cycle),
// inc advances, clear zeroes; timeout is high while the count equals LIMIT.
module bus_wait_timer #(
  parameter  int LIMIT = 255,
  localparam int CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          timeout
);

  assign timeout = (cnt == CW'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (clear)          cnt <= '0;
    else if (start)          cnt <= CW'(1);
    else if (inc && !timeout) cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// N-slave data-side bus fabric: region decode, registered read mux, wait
// arbitration with timeout and abort. SOC_BUS_ERR_CAPTURE_EN adds abort capture.
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int N_SLV    = 4,
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int RSEL_LSB = 28,
  parameter logic [N_SLV*(AW-RSEL_LSB)-1:0] SLV_REGION = {REG_GPIO, REG_UART, REG_ROM, REG_RAM},
  parameter int DEFAULT_SLV = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
`ifdef SOC_BUS_ERR_CAPTURE_EN
  output logic [AW-1:0] err_addr,
  output logic          err_wr,
  output logic          err_valid,
  input  logic          err_clr,
`endif
  soc_bus_fabric_if.slave bus
);

  localparam int RW = AW - RSEL_LSB;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [N_SLV-1:0] DEF_ONEHOT = N_SLV'(1) << DEFAULT_SLV;

  bus_state_t       state;
  logic [N_SLV-1:0] hit, ce, sel_d, wsel;
  logic [RW-1:0]    region;
  logic [DW-1:0]    rdata;
  logic             unmapped, stall, wait_hit, tmo, abort_evt, abort_q;
  logic             t_start, t_clear, t_inc;
  logic [CW-1:0]    cnt;

  assign region = bus.m_addr[AW-1:RSEL_LSB];

  for (genvar i = 0; i < N_SLV; i++) begin : g_hit
    assign hit[i] = bus.m_cen && (region == SLV_REGION[i*RW +: RW]);
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    ce = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        ce    = '0;
        ce[i] = 1'b1;
      end
    end
  end

  assign unmapped = bus.m_cen && (hit == '0);
  assign wait_hit = |(wsel & bus.s_wait);

  always_comb begin
    case (state)
      ST_IDLE: stall = |(ce & bus.s_wait);
      ST_WAIT: stall = wait_hit && !tmo;
      default: stall = 1'b0;
    endcase
  end

  // A slave releasing on the limit cycle completes normally.
  assign abort_evt = (state == ST_WAIT) ? (wait_hit && tmo) : unmapped;

  assign t_start = (state == ST_IDLE) && stall;
  assign t_inc   = (state == ST_WAIT) && wait_hit && !tmo;
  assign t_clear = (state == ST_WAIT) && (!wait_hit || tmo);

  bus_wait_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (t_start),
    .clear   (t_clear),
    .inc     (t_inc),
    .cnt     (cnt),
    .timeout (tmo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_d   <= DEF_ONEHOT;
      wsel    <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_evt;
      if (!stall) sel_d <= ce;
      case (state)
        ST_IDLE: if (stall) begin
          state <= ST_WAIT;
          wsel  <= ce;
        end
        ST_WAIT: begin
          if (!wait_hit) state <= ST_IDLE;
          else if (tmo)  state <= ST_ERR;
        end
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_SLV; i++)
      if (sel_d[i]) rdata = bus.s_rdata[i*DW +: DW];
  end

  assign bus.m_rdata = rdata;
  assign bus.m_wait  = stall;
  assign bus.m_abort = abort_q;
  assign bus.s_ce    = ce;
  assign bus.s_addr  = bus.m_addr;
  assign bus.s_wen   = bus.m_wen;
  assign bus.s_flag  = bus.m_flag;
  assign bus.s_wdata = bus.m_wdata;

`ifdef SOC_BUS_ERR_CAPTURE_EN
  // First abort wins; a clear in the same cycle as an abort leaves it empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr  <= '0;
      err_wr    <= 1'b0;
      err_valid <= 1'b0;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end else if (abort_evt && !err_valid) begin
      err_valid <= 1'b1;
      err_addr  <= bus.m_addr;
      err_wr    <= bus.m_wen;
    end
  end
`endif

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric (TIMEOUT_CYC=8); covers decode, wait,
// unmapped abort, timeout, limit-cycle release, reset mid-wait, and capture.
module tb_soc_bus_fabric;
  import soc_bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_hi;

  always #5 clk = ~clk;

  soc_bus_fabric_if #(.N_SLV(4), .DW(32), .AW(32)) bus ();

`ifdef SOC_BUS_ERR_CAPTURE_EN
  logic [31:0] err_addr;
  logic        err_wr, err_valid, err_clr;
`endif

  soc_bus_fabric #(.TIMEOUT_CYC(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SOC_BUS_ERR_CAPTURE_EN
    .err_addr  (err_addr),
    .err_wr    (err_wr),
    .err_valid (err_valid),
    .err_clr   (err_clr),
`endif
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst         = 1'b1;
    bus.m_addr  = '0;
    bus.m_cen   = 1'b0;
    bus.m_wen   = 1'b0;
    bus.m_flag  = '0;
    bus.m_wdata = '0;
    bus.s_wait  = '0;
    bus.s_rdata = {32'h6060_6060, 32'h0000_0055, 32'hE3A0_0001, 32'h1234_5678};
`ifdef SOC_BUS_ERR_CAPTURE_EN
    err_clr = 1'b0;
`endif
    tick;
    #1;
    chk("rst_wait",  64'(bus.m_wait),    64'd0);
    chk("rst_abort", 64'(bus.m_abort),   64'd0);
    chk("rst_sel",   64'(u_dut.sel_d),   64'h1);
    chk("rst_rdata", 64'(bus.m_rdata),   64'h1234_5678);
`ifdef SOC_BUS_ERR_CAPTURE_EN
    chk("rst_errv",  64'(err_valid),     64'd0);
`endif
    rst = 1'b0;
    tick;

    // ROM read
    bus.m_addr = 32'h0000_0010; bus.m_cen = 1'b1; bus.m_wen = 1'b0;
    #1;
    chk("rom_ce",    64'(bus.s_ce),   64'b0010);
    chk("rom_wait",  64'(bus.m_wait), 64'd0);
    tick;
    bus.m_cen = 1'b0;
    #1;
    chk("rom_rdata", 64'(bus.m_rdata), 64'hE3A0_0001);
    chk("rom_wait2", 64'(bus.m_wait),  64'd0);
    tick;

    // UART write
    bus.m_addr = 32'hE000_0004; bus.m_cen = 1'b1; bus.m_wen = 1'b1;
    bus.m_wdata = 32'h41; bus.m_flag = 4'b0001;
    #1;
    chk("wr_ce",    64'(bus.s_ce),    64'b0100);
    chk("wr_wdata", 64'(bus.s_wdata), 64'h41);
    chk("wr_flag",  64'(bus.s_flag),  64'b0001);
    chk("wr_wen",   64'(bus.s_wen),   64'd1);
    chk("wr_addr",  64'(bus.s_addr),  64'hE000_0004);
    tick;
    bus.m_cen = 1'b0; bus.m_wen = 1'b0;
    #1;
    chk("wr_abort", 64'(bus.m_abort), 64'd0);
    chk("wr_ce0",   64'(bus.s_ce),    64'b0000);
    tick;

    // RAM read with 3 wait cycles
    bus.m_addr = 32'h4000_0000; bus.m_cen = 1'b1;
    n_hi = 0;
    for (int k = 0; k < 4; k++) begin
      bus.s_wait = (k < 3) ? 4'b0001 : 4'b0000;
      #1;
      if (bus.m_wait) n_hi++;
      if (k == 1) chk("ws_sel_hold", 64'(u_dut.sel_d), 64'b0000);
      tick;
    end
    bus.m_cen = 1'b0;
    #1;
    chk("ws_cycles", 64'(n_hi),        64'd3);
    chk("ws_rdata",  64'(bus.m_rdata), 64'h1234_5678);
    tick;

    // Unmapped access
    bus.m_addr = 32'h7000_0000; bus.m_cen = 1'b1;
    #1;
    chk("um_ce",   64'(bus.s_ce),   64'b0000);
    chk("um_wait", 64'(bus.m_wait), 64'd0);
    tick;
    bus.m_cen = 1'b0;
    #1;
    chk("um_abort", 64'(bus.m_abort), 64'd1);
    chk("um_rdata", 64'(bus.m_rdata), 64'd0);
`ifdef SOC_BUS_ERR_CAPTURE_EN
    chk("um_errv",  64'(err_valid), 64'd1);
    chk("um_erra",  64'(err_addr),  64'h7000_0000);
    chk("um_errw",  64'(err_wr),    64'd0);
`endif
    tick;
    #1;
    chk("um_abort_end", 64'(bus.m_abort), 64'd0);

    // Timeout: RAM wait stuck
    bus.m_addr = 32'h4000_0000; bus.m_cen = 1'b1; bus.s_wait = 4'b0001;
    n_hi = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!bus.m_wait) break;
      n_hi++;
      tick;
    end
    chk("to_cycles", 64'(n_hi),        64'd8);
    chk("to_abort0", 64'(bus.m_abort), 64'd0);
    tick;
    bus.m_cen = 1'b0; bus.s_wait = 4'b0000;
    #1;
    chk("to_abort",  64'(bus.m_abort), 64'd1);
    chk("to_err",    64'(u_dut.state), 64'(ST_ERR));
    chk("to_wait",   64'(bus.m_wait),  64'd0);
`ifdef SOC_BUS_ERR_CAPTURE_EN
    chk("to_erra_keep", 64'(err_addr), 64'h7000_0000);
`endif
    tick;
    #1;
    chk("to_abort_end", 64'(bus.m_abort), 64'd0);
    chk("to_idle",      64'(u_dut.state), 64'(ST_IDLE));
    chk("to_cnt",       64'(u_dut.cnt),   64'd0);

    // Slave releases on the limit cycle: normal completion, no abort
    bus.m_addr = 32'h4000_0000; bus.m_cen = 1'b1;
    n_hi = 0;
    for (int k = 0; k < 9; k++) begin
      bus.s_wait = (k < 8) ? 4'b0001 : 4'b0000;
      #1;
      if (bus.m_wait) n_hi++;
      tick;
    end
    bus.m_cen = 1'b0;
    #1;
    chk("lim_cycles", 64'(n_hi),        64'd8);
    chk("lim_abort",  64'(bus.m_abort), 64'd0);
    chk("lim_rdata",  64'(bus.m_rdata), 64'h1234_5678);
    tick;

`ifdef SOC_BUS_ERR_CAPTURE_EN
    // Clear beats a same-cycle abort; next abort recaptures
    err_clr = 1'b1; bus.m_addr = 32'h8000_0000; bus.m_cen = 1'b1; bus.m_wen = 1'b1;
    tick;
    err_clr = 1'b0; bus.m_addr = 32'h9000_0000;
    #1;
    chk("clr_errv", 64'(err_valid), 64'd0);
    tick;
    bus.m_cen = 1'b0; bus.m_wen = 1'b0;
    #1;
    chk("cap_errv", 64'(err_valid), 64'd1);
    chk("cap_erra", 64'(err_addr),  64'h9000_0000);
    chk("cap_errw", 64'(err_wr),    64'd1);
    tick;
`endif

    // Reset during the second wait cycle
    bus.m_addr = 32'h4000_0000; bus.m_cen = 1'b1; bus.s_wait = 4'b0001;
    #1;
    chk("rw_wait1", 64'(bus.m_wait), 64'd1);
    tick;
    rst = 1'b1;
    #1;
    chk("rw_wait2", 64'(bus.m_wait), 64'd1);
    tick;
    rst = 1'b0; bus.m_cen = 1'b0;
    #1;
    chk("rw_wait",  64'(bus.m_wait),  64'd0);
    chk("rw_abort", 64'(bus.m_abort), 64'd0);
    chk("rw_sel",   64'(u_dut.sel_d), 64'b0001);
    chk("rw_cnt",   64'(u_dut.cnt),   64'd0);
    chk("rw_state", 64'(u_dut.state), 64'(ST_IDLE));
`ifdef SOC_BUS_ERR_CAPTURE_EN
    chk("rw_errv",  64'(err_valid),   64'd0);
`endif
    bus.s_wait = 4'b0000;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
